// File: rtl/dna_search_sequencer_if.sv
// Handshake bundle between the search sequencer (master) and the DNA pattern searcher (slave).
// The master launches a search with a start/length pair; the slave answers with a done pulse and its result.
interface dna_search_sequencer_if;
  logic        ready;
  logic [15:0] dna_start;
  logic [15:0] dna_length;
  logic        done;
  logic        found_it;
  logic [15:0] found_location;
  logic        error;

  modport master (
    output ready, dna_start, dna_length,
    input  done, found_it, found_location, error
  );

  modport slave (
    input  ready, dna_start, dna_length,
    output done, found_it, found_location, error
  );
endinterface

// File: rtl/dna_search_sequencer.sv
// Repeatedly launches the DNA searcher over a region to collect every match.
// Each match location is queued in a FIFO; the next search starts one past the previous hit.
module dna_search_sequencer #(
  parameter int PAT_LEN = 8,
  parameter int DEPTH   = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   go_i,
  input  logic [15:0]            region_start_i,
  input  logic [15:0]            region_length_i,
  output logic                   busy_o,
  output logic                   all_done_o,
  output logic                   error_o,
  output logic [7:0]             match_count_o,
  dna_search_sequencer_if.master srch,
  output logic                   loc_valid_o,
  output logic [15:0]            loc_data_o,
  input  logic                   loc_pop_i
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {IDLE, ISSUE, GUARD, WAIT, STALL, DONE} state_e;

  state_e      state_q, state_d;
  logic [15:0] regionStart_q, regionStart_d;
  logic [16:0] regionEnd_q, regionEnd_d;
  logic [15:0] curStart_q, curStart_d;
  logic [15:0] curLen_q, curLen_d;
  logic        error_q, error_d;
  logic [7:0]  matchCount_q, matchCount_d;
  logic [15:0] pendLoc_q, pendLoc_d;
  logic        srchReady_q, srchReady_d;

  logic [15:0] mem_q [DEPTH];
  logic [AW-1:0] wrPtr_q, rdPtr_q;
  logic [AW:0]   count_q;

  logic [15:0] hitLoc;
  logic [16:0] nextStart;
  logic [17:0] remLen;
  logic        remShort;
  logic        outOfRange;
  logic        fifoFull;
  logic        popEn;
  logic        pushEn;
  logic        fifoClear;
  logic        doAdvance;

  // In STALL the hit was latched earlier; in WAIT it comes straight from the searcher.
  assign hitLoc     = (state_q == STALL) ? pendLoc_q : srch.found_location;
  assign nextStart  = {1'b0, hitLoc} + 17'd1;
  assign remLen     = {1'b0, regionEnd_q} - {1'b0, nextStart};
  assign remShort   = remLen[17] || (remLen[16:0] < 17'(PAT_LEN));
  assign outOfRange = (srch.found_location < regionStart_q) ||
                      ({1'b0, srch.found_location} >= regionEnd_q);
  assign fifoFull   = (count_q == (AW+1)'(DEPTH));
  assign popEn      = loc_pop_i && (count_q != '0);

  always_comb begin
    state_d       = state_q;
    regionStart_d = regionStart_q;
    regionEnd_d   = regionEnd_q;
    curStart_d    = curStart_q;
    curLen_d      = curLen_q;
    error_d       = error_q;
    matchCount_d  = matchCount_q;
    pendLoc_d     = pendLoc_q;
    pushEn        = 1'b0;
    fifoClear     = 1'b0;
    doAdvance     = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (go_i) begin
          regionStart_d = region_start_i;
          regionEnd_d   = {1'b0, region_start_i} + {1'b0, region_length_i};
          matchCount_d  = 8'd0;
          error_d       = 1'b0;
          fifoClear     = 1'b1;
          if (region_length_i < 16'(PAT_LEN)) begin
            state_d = DONE;
          end else begin
            curStart_d = region_start_i;
            curLen_d   = region_length_i;
            state_d    = ISSUE;
          end
        end
      end
      ISSUE: state_d = GUARD;
      // GUARD swallows a done that may still be asserted from the previous search.
      GUARD: state_d = WAIT;
      WAIT: begin
        if (srch.done) begin
          if (srch.error) begin
            error_d = 1'b1;
            state_d = DONE;
          end else if (!srch.found_it) begin
            state_d = DONE;
          end else if (outOfRange) begin
            error_d = 1'b1;
            state_d = DONE;
          end else if (fifoFull) begin
            pendLoc_d = srch.found_location;
            state_d   = STALL;
          end else begin
            doAdvance = 1'b1;
          end
        end
      end
      STALL: begin
        if (!fifoFull) doAdvance = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (doAdvance) begin
      pushEn       = 1'b1;
      matchCount_d = (matchCount_q == 8'hFF) ? 8'hFF : matchCount_q + 8'd1;
      if (remShort) begin
        state_d = DONE;
      end else begin
        curStart_d = nextStart[15:0];
        curLen_d   = remLen[15:0];
        state_d    = ISSUE;
      end
    end
  end

  assign srchReady_d = (state_d == ISSUE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      regionStart_q <= '0;
      regionEnd_q   <= '0;
      curStart_q    <= '0;
      curLen_q      <= '0;
      error_q       <= 1'b0;
      matchCount_q  <= '0;
      pendLoc_q     <= '0;
      srchReady_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      regionStart_q <= regionStart_d;
      regionEnd_q   <= regionEnd_d;
      curStart_q    <= curStart_d;
      curLen_q      <= curLen_d;
      error_q       <= error_d;
      matchCount_q  <= matchCount_d;
      pendLoc_q     <= pendLoc_d;
      srchReady_q   <= srchReady_d;
    end
  end

  // A simultaneous push and pop leaves the occupancy unchanged.
  always_ff @(posedge clk_i) begin
    if (rst_i || fifoClear) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (pushEn) wrPtr_q <= wrPtr_q + 1'b1;
      if (popEn)  rdPtr_q <= rdPtr_q + 1'b1;
      count_q <= count_q + (AW+1)'(pushEn) - (AW+1)'(popEn);
    end
  end

  always_ff @(posedge clk_i) begin
    if (pushEn) mem_q[wrPtr_q] <= hitLoc;
  end

  assign busy_o         = (state_q != IDLE) && (state_q != DONE);
  assign all_done_o     = (state_q == DONE);
  assign error_o        = error_q;
  assign match_count_o  = matchCount_q;
  assign srch.ready      = srchReady_q;
  assign srch.dna_start  = curStart_q;
  assign srch.dna_length = curLen_q;
  assign loc_valid_o    = (count_q != '0);
  assign loc_data_o     = loc_valid_o ? mem_q[rdPtr_q] : 16'd0;

endmodule

// File: tb/tb_dna_search_sequencer.sv
// Self-checking bench for dna_search_sequencer: a behavioural searcher answers each launch,
// and a queue of expected match locations is compared against the FIFO as it is drained.
module tb_dna_search_sequencer;
  localparam int PAT_LEN = 8;
  localparam int DEPTH   = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        go;
  logic [15:0] regionStart, regionLength;
  logic        busy, allDone, err;
  logic [7:0]  matchCount;
  logic        locValid;
  logic [15:0] locData;
  logic        locPop;

  int checks = 0;
  int errors = 0;
  logic [15:0] expQ [$];

  dna_search_sequencer_if srch ();

  dna_search_sequencer #(.PAT_LEN(PAT_LEN), .DEPTH(DEPTH)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .go_i           (go),
    .region_start_i (regionStart),
    .region_length_i(regionLength),
    .busy_o         (busy),
    .all_done_o     (allDone),
    .error_o        (err),
    .match_count_o  (matchCount),
    .srch           (srch),
    .loc_valid_o    (locValid),
    .loc_data_o     (locData),
    .loc_pop_i      (locPop)
  );

  always #5 clk = ~clk;

  task automatic startRun(input logic [15:0] s, input logic [15:0] l);
    @(negedge clk);
    regionStart = s;
    regionLength = l;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic waitReady(output bit ok, output logic [15:0] st, output logic [15:0] ln);
    ok = 1'b0;
    st = '0;
    ln = '0;
    for (int i = 0; i < 50; i++) begin
      if (srch.ready === 1'b1) begin
        ok = 1'b1;
        st = srch.dna_start;
        ln = srch.dna_length;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Answers a launch seen at the current negedge; done is sampled three cycles after ready.
  task automatic respond(input bit found, input logic [15:0] loc, input bit e);
    repeat (3) @(negedge clk);
    srch.done = 1'b1;
    srch.found_it = found;
    srch.found_location = loc;
    srch.error = e;
    @(negedge clk);
    srch.done = 1'b0;
    srch.found_it = 1'b0;
    srch.found_location = '0;
    srch.error = 1'b0;
  endtask

  task automatic watchNoReady(input int n, output bit saw);
    saw = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (srch.ready === 1'b1) saw = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic drainAndCompare(input string tag);
    logic [15:0] exp;
    locPop = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (locValid !== 1'b1) break;
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL %s pop%0d: got %0d want no entry", tag, i, locData);
      end else begin
        exp = expQ.pop_front();
        if (locData !== exp) begin
          errors++;
          $display("[TB] FAIL %s pop%0d: got %0d want %0d", tag, i, locData, exp);
        end
      end
      locPop = 1'b1;
      @(negedge clk);
    end
    locPop = 1'b0;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s leftover: got %0d unread want 0", tag, expQ.size());
      expQ.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, allDone, err, matchCount, srch.ready, srch.dna_start, srch.dna_length, locValid, locData} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_values: busy=%b done=%b err=%b cnt=%0d rdy=%b st=%0d len=%0d v=%b d=%0d want all 0",
               busy, allDone, err, matchCount, srch.ready, srch.dna_start, srch.dna_length, locValid, locData);
    end
    rst = 1'b0;
  endtask

  task automatic test_multi_match();
    logic [15:0] eS [3] = '{16'd5, 16'd21, 16'd41};
    logic [15:0] eL [3] = '{16'd100, 16'd84, 16'd64};
    logic [15:0] hit [3] = '{16'd20, 16'd40, 16'd0};
    bit f [3] = '{1'b1, 1'b1, 1'b0};
    bit ok;
    logic [15:0] st, ln;
    startRun(16'd5, 16'd100);
    checks++;
    if (srch.ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL go_latency: ready=%b busy=%b want 1/1", srch.ready, busy);
    end
    for (int i = 0; i < 3; i++) begin
      waitReady(ok, st, ln);
      checks++;
      if (!ok || st !== eS[i] || ln !== eL[i]) begin
        errors++;
        $display("[TB] FAIL multi_search%0d: ok=%b start/len got %0d/%0d want %0d/%0d", i, ok, st, ln, eS[i], eL[i]);
      end
      if (f[i]) expQ.push_back(hit[i]);
      respond(f[i], hit[i], 1'b0);
    end
    checks++;
    if (allDone !== 1'b1 || busy !== 1'b0 || matchCount !== 8'd2 || err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL multi_status: done=%b busy=%b cnt=%0d err=%b want 1/0/2/0", allDone, busy, matchCount, err);
    end
    drainAndCompare("multi");
  endtask

  task automatic test_short_region();
    bit saw;
    startRun(16'd5, 16'd7);
    checks++;
    if (allDone !== 1'b1 || busy !== 1'b0 || matchCount !== 8'd0) begin
      errors++;
      $display("[TB] FAIL short_status: done=%b busy=%b cnt=%0d want 1/0/0", allDone, busy, matchCount);
    end
    watchNoReady(6, saw);
    checks++;
    if (saw !== 1'b0) begin
      errors++;
      $display("[TB] FAIL short_no_ready: saw ready=%b want 0", saw);
    end
  endtask

  task automatic test_tail_hit();
    bit ok, saw;
    logic [15:0] st, ln;
    startRun(16'd5, 16'd100);
    waitReady(ok, st, ln);
    checks++;
    if (!ok || st !== 16'd5 || ln !== 16'd100) begin
      errors++;
      $display("[TB] FAIL tail_search: ok=%b start/len got %0d/%0d want 5/100", ok, st, ln);
    end
    expQ.push_back(16'd97);
    respond(1'b1, 16'd97, 1'b0);
    checks++;
    if (allDone !== 1'b1 || matchCount !== 8'd1 || locValid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL tail_status: done=%b cnt=%0d valid=%b want 1/1/1", allDone, matchCount, locValid);
    end
    watchNoReady(6, saw);
    checks++;
    if (saw !== 1'b0) begin
      errors++;
      $display("[TB] FAIL tail_no_ready: saw ready=%b want 0", saw);
    end
    drainAndCompare("tail");
  endtask

  task automatic test_stall();
    bit ok, saw;
    logic [15:0] st, ln, expS, expL, loc, exp;
    expS = 16'd0;
    expL = 16'd1000;
    locPop = 1'b0;
    startRun(16'd0, 16'd1000);
    for (int i = 0; i < 10; i++) begin
      loc = (i < 9) ? 16'((i + 1) * 10) : 16'd995;
      waitReady(ok, st, ln);
      checks++;
      if (!ok || st !== expS || ln !== expL) begin
        errors++;
        $display("[TB] FAIL stall_search%0d: ok=%b start/len got %0d/%0d want %0d/%0d", i, ok, st, ln, expS, expL);
      end
      expQ.push_back(loc);
      respond(1'b1, loc, 1'b0);
      expS = loc + 16'd1;
      expL = 16'd1000 - expS;
      if (i == 8) begin
        checks++;
        if (busy !== 1'b1 || allDone !== 1'b0 || matchCount !== 8'd8 || locValid !== 1'b1) begin
          errors++;
          $display("[TB] FAIL stall_status: busy=%b done=%b cnt=%0d valid=%b want 1/0/8/1", busy, allDone, matchCount, locValid);
        end
        watchNoReady(6, saw);
        checks++;
        if (saw !== 1'b0) begin
          errors++;
          $display("[TB] FAIL stall_no_ready: saw ready=%b want 0", saw);
        end
        exp = expQ.pop_front();
        checks++;
        if (locData !== exp) begin
          errors++;
          $display("[TB] FAIL stall_first_pop: got %0d want %0d", locData, exp);
        end
        locPop = 1'b1;
        @(negedge clk);
        locPop = 1'b0;
      end
    end
    drainAndCompare("stall");
    checks++;
    if (allDone !== 1'b1 || matchCount !== 8'd10 || err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stall_final: done=%b cnt=%0d err=%b want 1/10/0", allDone, matchCount, err);
    end
  endtask

  task automatic test_error();
    bit ok;
    logic [15:0] st, ln;
    startRun(16'd5, 16'd100);
    waitReady(ok, st, ln);
    respond(1'b1, 16'd30, 1'b1);
    checks++;
    if (err !== 1'b1 || allDone !== 1'b1 || locValid !== 1'b0 || matchCount !== 8'd0) begin
      errors++;
      $display("[TB] FAIL error_priority: err=%b done=%b valid=%b cnt=%0d want 1/1/0/0", err, allDone, locValid, matchCount);
    end
    startRun(16'd5, 16'd100);
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL error_cleared_on_go: err=%b busy=%b want 0/1", err, busy);
    end
    waitReady(ok, st, ln);
    respond(1'b1, 16'd200, 1'b0);
    checks++;
    if (err !== 1'b1 || allDone !== 1'b1 || locValid !== 1'b0 || matchCount !== 8'd0) begin
      errors++;
      $display("[TB] FAIL out_of_range: err=%b done=%b valid=%b cnt=%0d want 1/1/0/0", err, allDone, locValid, matchCount);
    end
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    logic [15:0] st, ln;
    startRun(16'd5, 16'd100);
    waitReady(ok, st, ln);
    respond(1'b1, 16'd20, 1'b0);
    waitReady(ok, st, ln);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    srch.done = 1'b1;
    srch.found_it = 1'b1;
    srch.found_location = 16'd50;
    @(negedge clk);
    rst = 1'b0;
    srch.done = 1'b0;
    srch.found_it = 1'b0;
    srch.found_location = '0;
    checks++;
    if ({busy, allDone, err, matchCount, srch.ready, srch.dna_start, srch.dna_length, locValid, locData} !== '0) begin
      errors++;
      $display("[TB] FAIL midrun_reset: busy=%b done=%b err=%b cnt=%0d rdy=%b st=%0d len=%0d v=%b d=%0d want all 0",
               busy, allDone, err, matchCount, srch.ready, srch.dna_start, srch.dna_length, locValid, locData);
    end
    startRun(16'd0, 16'd50);
    waitReady(ok, st, ln);
    checks++;
    if (!ok || st !== 16'd0 || ln !== 16'd50) begin
      errors++;
      $display("[TB] FAIL fresh_search: ok=%b start/len got %0d/%0d want 0/50", ok, st, ln);
    end
    respond(1'b0, 16'd0, 1'b0);
    checks++;
    if (allDone !== 1'b1 || matchCount !== 8'd0 || locValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fresh_status: done=%b cnt=%0d valid=%b want 1/0/0", allDone, matchCount, locValid);
    end
  endtask

  initial begin
    rst = 1'b1;
    go = 1'b0;
    regionStart = '0;
    regionLength = '0;
    locPop = 1'b0;
    srch.done = 1'b0;
    srch.found_it = 1'b0;
    srch.found_location = '0;
    srch.error = 1'b0;
    $display("[TB] starting dna_search_sequencer bench");
    test_reset();
    test_multi_match();
    test_short_region();
    test_tail_hit();
    test_stall();
    test_error();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
